text_console_writer: RTL and testbench

//  Writer side of the character display's text buffer; the raster reader scans the same buffer for display.

---
 rtl/text_console_writer_pkg.sv | 30 +++
 rtl/text_console_writer_if.sv | 24 ++
 rtl/text_console_writer_cell_addr.sv | 31 +++
 rtl/text_console_writer.sv | 157 +++++++++++++++
 tb/tb_text_console_writer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the text console writer: screen geometry defaults,
// control codes, writer state encoding and the printable-character test.
package text_console_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 25;

    localparam int ADDR_W = 11;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;

    localparam logic [7:0] CODE_BS  = 8'h08;
    localparam logic [7:0] CODE_LF  = 8'h0A;
    localparam logic [7:0] CODE_FF  = 8'h0C;
    localparam logic [7:0] CODE_CR  = 8'h0D;
    localparam logic [7:0] CODE_DEL = 8'h7F;
    localparam logic [7:0] BLANK    = 8'h20;

    typedef enum logic [1:0] {
        INIT_CLR = 2'd0,
        IDLE     = 2'd1,
        ROW_CLR  = 2'd2,
        SCR_CLR  = 2'd3
    } writer_state_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= BLANK) && (code != CODE_DEL);
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream handshake into the console writer: code plus colour
// attribute, transferred when valid and ready are both high at a clock edge.
interface text_console_writer_if;

    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_code;
    logic [7:0] char_attr;

    modport master (
        output char_valid,
        output char_code,
        output char_attr,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_code,
        input  char_attr,
        output char_ready
    );

endinterface

// File: rtl/text_console_writer_cell_addr.sv
// Combinational cell index row*COLS + col, shared by character writes and
// the row-clear start address.
module cell_addr
    import text_console_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_x;
    logic [ADDR_W-1:0] col_x;
    logic [ADDR_W-1:0] row_base;

    assign row_x = ADDR_W'(row);
    assign col_x = ADDR_W'(col);

    // The default 80-column geometry avoids a multiplier: 80 = 64 + 16.
    generate
        if (COLS == 80) begin : g_shift_add
            assign row_base = (row_x << 6) + (row_x << 4);
        end else begin : g_mul
            assign row_base = row_x * ADDR_W'(COLS);
        end
    endgenerate

    assign addr = row_base + col_x;

endmodule

// File: rtl/text_console_writer.sv
// Writer side of the character display text buffer: consumes a character
// stream, tracks the cursor and issues {attr, ascii} cell writes and blanking.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS           = DEFAULT_COLS,
    parameter int         ROWS           = DEFAULT_ROWS,
    parameter logic [7:0] CLEAR_ATTR     = 8'h07,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    text_console_writer_if.slave chr,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_address,
    output logic [15:0]          wr_data,
    output logic [COL_W-1:0]     cursor_col,
    output logic [ROW_W-1:0]     cursor_row,
    output logic                 busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_SPAN    = ADDR_W'(COLS - 1);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [15:0]       BLANK_CELL  = {CLEAR_ATTR, BLANK};
    localparam writer_state_t     RESET_STATE = CLEAR_ON_RESET ? INIT_CLR : IDLE;

    writer_state_t     state_q, state_d;
    logic              ready_q;
    logic              busy_q;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] clr_end_q, clr_end_d;

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_address_d;
    logic [15:0]       wr_data_d;
    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;

    logic              accept;
    logic [ROW_W-1:0]  next_row;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_row_base;

    assign accept   = chr.char_valid && ready_q;
    assign next_row = (cursor_row == LAST_ROW) ? '0 : cursor_row + ROW_W'(1);

    cell_addr #(.COLS(COLS)) u_cur_addr (
        .row  (cursor_row),
        .col  (cursor_col),
        .addr (cur_addr)
    );

    cell_addr #(.COLS(COLS)) u_next_row_addr (
        .row  (next_row),
        .col  ('0),
        .addr (next_row_base)
    );

    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address;
        wr_data_d    = wr_data;
        col_d        = cursor_col;
        row_d        = cursor_row;
        clr_addr_d   = clr_addr_q;
        clr_end_d    = clr_end_q;

        unique case (state_q)
            INIT_CLR, ROW_CLR, SCR_CLR: begin
                wr_en_d      = 1'b1;
                wr_address_d = clr_addr_q;
                wr_data_d    = BLANK_CELL;
                clr_addr_d   = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == clr_end_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (is_printable(chr.char_code)) begin
                        wr_en_d      = 1'b1;
                        wr_address_d = cur_addr;
                        wr_data_d    = {chr.char_attr, chr.char_code};
                        if (cursor_col == LAST_COL) begin
                            // Wrapping onto a new line blanks that line before accepting more.
                            col_d      = '0;
                            row_d      = next_row;
                            state_d    = ROW_CLR;
                            clr_addr_d = next_row_base;
                            clr_end_d  = next_row_base + ROW_SPAN;
                        end else begin
                            col_d = cursor_col + COL_W'(1);
                        end
                    end else begin
                        case (chr.char_code)
                            CODE_LF: begin
                                col_d      = '0;
                                row_d      = next_row;
                                state_d    = ROW_CLR;
                                clr_addr_d = next_row_base;
                                clr_end_d  = next_row_base + ROW_SPAN;
                            end
                            CODE_CR: col_d = '0;
                            CODE_BS: begin
                                if (cursor_col != '0) begin
                                    col_d = cursor_col - COL_W'(1);
                                end
                            end
                            CODE_FF: begin
                                col_d      = '0;
                                row_d      = '0;
                                state_d    = SCR_CLR;
                                clr_addr_d = '0;
                                clr_end_d  = LAST_CELL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= RESET_STATE;
            ready_q    <= !CLEAR_ON_RESET;
            busy_q     <= CLEAR_ON_RESET;
            clr_addr_q <= '0;
            clr_end_q  <= LAST_CELL;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
            clr_addr_q <= clr_addr_d;
            clr_end_q  <= clr_end_d;
            wr_en      <= wr_en_d;
            wr_address <= wr_address_d;
            wr_data    <= wr_data_d;
            cursor_col <= col_d;
            cursor_row <= row_d;
        end
    end

    assign chr.char_ready = ready_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table for single codes plus
// hand-written sequences for clears, wrap, LF wrap, FF and mid-clear reset.
module tb_text_console_writer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        wr_en;
    logic [10:0] wr_address;
    logic [15:0] wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    text_console_writer_if cif ();

    text_console_writer dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .chr        (cif),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0]  code;
        logic [7:0]  attr;
        logic        exp_wr;
        logic [10:0] exp_addr;
        logic [15:0] exp_data;
        logic [6:0]  exp_col;
        logic [4:0]  exp_row;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] code, input logic [7:0] attr);
        int waited = 0;
        cif.char_code  = code;
        cif.char_attr  = attr;
        cif.char_valid = 1'b1;
        while (!cif.char_ready && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        if (!cif.char_ready) check("send_ready_timeout", cif.char_ready, 1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        cif.char_valid = 1'b0;
    endtask

    task automatic expect_clear(input string name, input int start, input int n);
        int errs = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            if (wr_en !== 1'b1 || wr_address !== 11'(start + k) || wr_data !== 16'h0720 ||
                (k < n - 1 && (busy !== 1'b1 || cif.char_ready !== 1'b0)))
                errs++;
        end
        check({name, "_cells"}, errs, 0);
        check({name, "_done"}, {busy, cif.char_ready}, 2'b01);
        @(negedge sys_clk);
        check({name, "_stop"}, wr_en, 0);
    endtask

    initial begin
        int errs;
        int waited;

        vecs[0] = '{8'h08, 8'h00, 1'b0, 11'd0, 16'h0000, 7'd1, 5'd0};
        vecs[1] = '{8'h0D, 8'h00, 1'b0, 11'd0, 16'h0000, 7'd0, 5'd0};
        vecs[2] = '{8'h08, 8'h00, 1'b0, 11'd0, 16'h0000, 7'd0, 5'd0};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 11'd0, 16'h0000, 7'd0, 5'd0};
        vecs[4] = '{8'h7F, 8'h55, 1'b0, 11'd0, 16'h0000, 7'd0, 5'd0};
        vecs[5] = '{8'h41, 8'h2F, 1'b1, 11'd0, 16'h2F41, 7'd1, 5'd0};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 11'd1, 16'h00FF, 7'd2, 5'd0};
        vecs[7] = '{8'h20, 8'h07, 1'b1, 11'd2, 16'h0720, 7'd3, 5'd0};
        vecs[8] = '{8'h1F, 8'hAA, 1'b0, 11'd0, 16'h0000, 7'd3, 5'd0};

        sys_rst_n      = 1'b0;
        cif.char_valid = 1'b0;
        cif.char_code  = 8'h00;
        cif.char_attr  = 8'h00;

        // Reset state and power-up clear
        repeat (3) @(negedge sys_clk);
        check("reset_state", {wr_en, wr_address, wr_data, cursor_col, cursor_row, cif.char_ready, busy},
              {1'b0, 11'd0, 16'd0, 7'd0, 5'd0, 1'b0, 1'b1});
        sys_rst_n = 1'b1;
        expect_clear("init_clr", 0, 2000);

        // Back-to-back "Hi" with valid held
        cif.char_code  = 8'h48;
        cif.char_attr  = 8'h1E;
        cif.char_valid = 1'b1;
        @(negedge sys_clk);
        check("hi_first", {wr_en, wr_address, wr_data}, {1'b1, 11'd0, 16'h1E48});
        cif.char_code = 8'h69;
        @(negedge sys_clk);
        cif.char_valid = 1'b0;
        check("hi_second", {wr_en, wr_address, wr_data}, {1'b1, 11'd1, 16'h1E69});
        check("hi_col", cursor_col, 2);

        // Single-code vector table
        foreach (vecs[i]) begin
            send(vecs[i].code, vecs[i].attr);
            check($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].exp_wr);
            if (vecs[i].exp_wr)
                check($sformatf("vec%0d_cell", i), {wr_address, wr_data}, {vecs[i].exp_addr, vecs[i].exp_data});
            check($sformatf("vec%0d_cursor", i), {cursor_row, cursor_col}, {vecs[i].exp_row, vecs[i].exp_col});
        end

        // CR from column 37
        for (int i = 0; i < 34; i++) send(8'h61, 8'h07);
        check("col37", cursor_col, 37);
        send(8'h0D, 8'h07);
        check("cr_col37", {wr_en, cursor_row, cursor_col}, {1'b0, 5'd0, 7'd0});

        // Full row of printables, then wrap clear of row 1
        errs = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h78, 8'h4A);
            if (wr_en !== 1'b1 || wr_address !== 11'(i) || wr_data !== 16'h4A78) errs++;
        end
        check("row0_writes", errs, 0);
        check("wrap_state", {wr_address, cursor_row, cursor_col, cif.char_ready, busy},
              {11'd79, 5'd1, 7'd0, 1'b0, 1'b1});
        expect_clear("wrap_clr", 80, 80);

        // LF wrap from row 24 col 5
        for (int i = 0; i < 23; i++) send(8'h0A, 8'h00);
        check("lf_row24", {cursor_row, cursor_col}, {5'd24, 7'd0});
        for (int i = 0; i < 5; i++) send(8'h7A, 8'h07);
        check("row24_last", {wr_address, cursor_row, cursor_col}, {11'd1924, 5'd24, 7'd5});
        send(8'h0A, 8'h00);
        check("lf_wrap_state", {wr_en, cursor_row, cursor_col, busy}, {1'b0, 5'd0, 7'd0, 1'b1});
        expect_clear("lf_wrap_clr", 0, 80);

        // Form feed clears the screen and homes the cursor
        for (int i = 0; i < 3; i++) send(8'h71, 8'h07);
        check("pre_ff_col", cursor_col, 3);
        send(8'h0C, 8'h00);
        check("ff_state", {wr_en, cursor_row, cursor_col, cif.char_ready, busy},
              {1'b0, 5'd0, 7'd0, 1'b0, 1'b1});
        expect_clear("ff_clr", 0, 2000);

        // Reset in the middle of a screen clear
        send(8'h0C, 8'h00);
        waited = 0;
        while (!(wr_en === 1'b1 && wr_address === 11'd700) && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        check("reach_700", wr_address, 700);
        #1 sys_rst_n = 1'b0;
        #1;
        check("mid_reset_state", {wr_en, wr_address, wr_data, cursor_col, cursor_row, cif.char_ready, busy},
              {1'b0, 11'd0, 16'd0, 7'd0, 5'd0, 1'b0, 1'b1});
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        expect_clear("restart_clr", 0, 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
